// File: rtl/clk_meas_pkg.sv
// rtl/clk_meas_pkg.sv - shared FSM state encoding and defaults for clk_freq_meter
// Purpose : measurement FSM state type and the default counter width.
// Ports   : none (package).
package clk_meas_pkg;

  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meas_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - synchronizer and rising-edge detector for the clock under test
// Purpose : brings sig_in into the clk domain through two flops, delays it one more
//           flop and flags a rising edge when the synchronized level is 1 and the
//           delayed level is 0. The edge is seen by the consumer 3 clk after sig_in rises.
// Ports   : clk     - reference clock
//           rst_n   - asynchronous active-low reset
//           sig_in  - asynchronous input signal
//           sync_o  - synchronized level of sig_in
//           rise_o  - one-cycle rising-edge flag
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic sync_o,
  output logic rise_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic dly_q,  dly_d;

  always_comb begin
    meta_d = sig_in;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~dly_q;

endmodule

// File: rtl/clk_freq_meter.sv
// rtl/clk_freq_meter.sv - period / duty measurement of a divided clock against clk
// Purpose : counts clk cycles between consecutive sig_in rising edges, splits them
//           into high and low time, flags whether the period is within tolerance
//           and pulses timeout when no edge arrives for TIMEOUT cycles.
// Ports   : clk, rst_n (async active-low), enable (level), sig_in (async)
//           period / high_time / low_time - last completed measurement
//           meas_valid - one-cycle pulse when the outputs above are updated
//           freq_ok    - last period within EXP_PERIOD +/- TOL
//           timeout    - one-cycle pulse on a missing edge
module clk_freq_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int TIMEOUT    = 1000,
  parameter int EXP_PERIOD = 4,
  parameter int TOL        = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic             meas_valid,
  output logic             freq_ok,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   EXP_C      = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   TOL_C      = (CNT_W+1)'(TOL);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Reset asserts asynchronously but is released through two flops so every
  // other flop leaves reset on a clean clk edge.
  logic rst_meta_q, rst_meta_d;
  logic rst_sync_q, rst_sync_d;

  always_comb begin
    rst_meta_d = 1'b1;
    rst_sync_d = rst_meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= rst_meta_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  logic rst_int_n;
  assign rst_int_n = rst_sync_q;

  logic sync_lvl, rise;

  sync_edge_det u_sync_edge_det (
    .clk    (clk),
    .rst_n  (rst_int_n),
    .sig_in (sig_in),
    .sync_o (sync_lvl),
    .rise_o (rise)
  );

  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic [CNT_W-1:0] low_time_q, low_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic             freq_ok_q, freq_ok_d;
  logic             timeout_q, timeout_d;

  // Deviation from the expected period, one bit wider so the subtraction never wraps.
  logic [CNT_W:0] per_ext, per_diff;
  logic           per_in_tol;

  always_comb begin
    per_ext    = {1'b0, per_cnt_q};
    per_diff   = (per_ext >= EXP_C) ? (per_ext - EXP_C) : (EXP_C - per_ext);
    per_in_tol = (per_diff <= TOL_C);
  end

  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    high_cnt_d   = high_cnt_q;
    low_cnt_d    = low_cnt_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    low_time_d   = low_time_q;
    freq_ok_d    = freq_ok_q;
    meas_valid_d = 1'b0;
    timeout_d    = 1'b0;

    if (!enable) begin
      state_d    = IDLE;
      per_cnt_d  = '0;
      high_cnt_d = '0;
      low_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          per_cnt_d  = '0;
          high_cnt_d = '0;
          low_cnt_d  = '0;
          state_d    = ARM;
        end
        ARM: begin
          if (rise) begin
            state_d    = MEASURE;
            per_cnt_d  = CNT_W'(1);
            high_cnt_d = CNT_W'(1);
            low_cnt_d  = '0;
          end else if (per_cnt_q >= TIMEOUT_M1) begin
            // Waiting cycles are counted 0..TIMEOUT-1, giving one pulse per TIMEOUT cycles.
            timeout_d = 1'b1;
            freq_ok_d = 1'b0;
            per_cnt_d = '0;
          end else begin
            per_cnt_d = sat_inc(per_cnt_q);
          end
        end
        MEASURE: begin
          // An edge takes priority over a timeout falling in the same cycle.
          if (rise) begin
            period_d     = per_cnt_q;
            high_time_d  = high_cnt_q;
            low_time_d   = low_cnt_q;
            freq_ok_d    = per_in_tol;
            meas_valid_d = 1'b1;
            per_cnt_d    = CNT_W'(1);
            high_cnt_d   = CNT_W'(1);
            low_cnt_d    = '0;
          end else if (per_cnt_q >= TIMEOUT_C) begin
            timeout_d  = 1'b1;
            freq_ok_d  = 1'b0;
            state_d    = ARM;
            per_cnt_d  = '0;
            high_cnt_d = '0;
            low_cnt_d  = '0;
          end else begin
            per_cnt_d = sat_inc(per_cnt_q);
            if (sync_lvl) high_cnt_d = sat_inc(high_cnt_q);
            else          low_cnt_d  = sat_inc(low_cnt_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q      <= IDLE;
      per_cnt_q    <= '0;
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      low_time_q   <= '0;
      meas_valid_q <= 1'b0;
      freq_ok_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      high_cnt_q   <= high_cnt_d;
      low_cnt_q    <= low_cnt_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      low_time_q   <= low_time_d;
      meas_valid_q <= meas_valid_d;
      freq_ok_q    <= freq_ok_d;
      timeout_q    <= timeout_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign low_time   = low_time_q;
  assign meas_valid = meas_valid_q;
  assign freq_ok    = freq_ok_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// tb/tb_clk_freq_meter.sv - scoreboard bench for clk_freq_meter
module tb_clk_freq_meter;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic sig_in = 1'b0;

  logic [W-1:0] period_a, high_a, low_a;
  logic [W-1:0] period_b, high_b, low_b;
  logic [W-1:0] period_c, high_c, low_c;
  logic mv_a, ok_a, to_a, mv_b, ok_b, to_b, mv_c, ok_c, to_c;

  always #5 clk = ~clk;

  clk_freq_meter #(.CNT_W(W), .TIMEOUT(1000), .EXP_PERIOD(4), .TOL(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
    .period(period_a), .high_time(high_a), .low_time(low_a),
    .meas_valid(mv_a), .freq_ok(ok_a), .timeout(to_a)
  );

  clk_freq_meter #(.CNT_W(W), .TIMEOUT(1000), .EXP_PERIOD(160), .TOL(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
    .period(period_b), .high_time(high_b), .low_time(low_b),
    .meas_valid(mv_b), .freq_ok(ok_b), .timeout(to_b)
  );

  clk_freq_meter #(.CNT_W(W), .TIMEOUT(1000), .EXP_PERIOD(168), .TOL(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
    .period(period_c), .high_time(high_c), .low_time(low_c),
    .meas_valid(mv_c), .freq_ok(ok_c), .timeout(to_c)
  );

  typedef struct {
    int hi;
    int lo;
  } meas_t;

  meas_t exp_q[$];
  int    to_cyc[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  bit    allow_to = 1'b0;
  bit    have_prev = 1'b0;
  int    prev_hi = 0;
  int    prev_lo = 0;

  function automatic bit ok_model(input int p, input int e, input int t);
    int d;
    d = (p > e) ? (p - e) : (e - p);
    return d <= t;
  endfunction

  task automatic check_meas();
    meas_t e;
    int    p;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_meas_valid: got meas_valid=1 period=%0d at cycle %0d, required no pulse", period_a, cyc);
    end else begin
      e = exp_q.pop_front();
      p = e.hi + e.lo;
      checks++; if ({mv_a, mv_b, mv_c} !== 3'b111) begin errors++; $display("FAIL valid_agree: got %b required 111", {mv_a, mv_b, mv_c}); end
      checks++; if (period_a !== W'(p)) begin errors++; $display("FAIL period: got %0d required %0d", period_a, p); end
      checks++; if (high_a !== W'(e.hi)) begin errors++; $display("FAIL high_time: got %0d required %0d", high_a, e.hi); end
      checks++; if (low_a !== W'(e.lo)) begin errors++; $display("FAIL low_time: got %0d required %0d", low_a, e.lo); end
      checks++; if ({period_b, high_b, low_b} !== {W'(p), W'(e.hi), W'(e.lo)}) begin errors++; $display("FAIL meas_b: got %0d/%0d/%0d required %0d/%0d/%0d", period_b, high_b, low_b, p, e.hi, e.lo); end
      checks++; if ({period_c, high_c, low_c} !== {W'(p), W'(e.hi), W'(e.lo)}) begin errors++; $display("FAIL meas_c: got %0d/%0d/%0d required %0d/%0d/%0d", period_c, high_c, low_c, p, e.hi, e.lo); end
      checks++; if (ok_a !== ok_model(p, 4, 0)) begin errors++; $display("FAIL freq_ok_a: got %b required %b for period %0d", ok_a, ok_model(p, 4, 0), p); end
      checks++; if (ok_b !== ok_model(p, 160, 0)) begin errors++; $display("FAIL freq_ok_b: got %b required %b for period %0d", ok_b, ok_model(p, 160, 0), p); end
      checks++; if (ok_c !== ok_model(p, 168, 1)) begin errors++; $display("FAIL freq_ok_c: got %b required %b for period %0d", ok_c, ok_model(p, 168, 1), p); end
    end
  endtask

  task automatic check_to();
    to_cyc.push_back(cyc);
    checks++;
    if ({to_a, to_b, to_c} !== 3'b111) begin errors++; $display("FAIL timeout_agree: got %b required 111", {to_a, to_b, to_c}); end
    if (!allow_to) begin
      checks++; errors++;
      $display("FAIL unexpected_timeout: got timeout=1 at cycle %0d, required 0", cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst_n) begin
      if (mv_a || mv_b || mv_c) check_meas();
      if (to_a || to_b || to_c) check_to();
    end
  end

  // Drives n periods of hi/lo cycles; each rising edge after the first scores the previous period.
  task automatic gen(input int hi, input int lo, input int n, input bit score);
    for (int k = 0; k < n; k++) begin
      if (score && have_prev) exp_q.push_back('{prev_hi, prev_lo});
      sig_in = 1'b1;
      repeat (hi) @(negedge clk);
      sig_in = 1'b0;
      repeat (lo) @(negedge clk);
      prev_hi   = hi;
      prev_lo   = lo;
      have_prev = score;
    end
  endtask

  task automatic final_edge();
    int n;
    if (have_prev) exp_q.push_back('{prev_hi, prev_lo});
    sig_in = 1'b1;
    repeat (2) @(negedge clk);
    sig_in = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    have_prev = 1'b0;
  endtask

  task automatic rearm();
    enable    = 1'b0;
    have_prev = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; enable = 1'b0; sig_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (period_a !== '0) begin errors++; $display("FAIL reset_period: got %0d required 0", period_a); end
    checks++; if (high_a !== '0) begin errors++; $display("FAIL reset_high: got %0d required 0", high_a); end
    checks++; if (low_a !== '0) begin errors++; $display("FAIL reset_low: got %0d required 0", low_a); end
    checks++; if (mv_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", mv_a); end
    checks++; if (ok_a !== 1'b0) begin errors++; $display("FAIL reset_freq_ok: got %b required 0", ok_a); end
    checks++; if (to_a !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b required 0", to_a); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_nominal();
    rearm();
    gen(2, 2, 10, 1'b1);
    final_edge();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL nominal_missing: got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_rate_change();
    rearm();
    gen(80, 80, 3, 1'b1);
    gen(115, 115, 3, 1'b1);
    final_edge();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rate_missing: got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_tolerance();
    rearm();
    gen(84, 83, 2, 1'b1);
    gen(85, 84, 2, 1'b1);
    gen(85, 85, 2, 1'b1);
    gen(83, 83, 1, 1'b1);
    final_edge();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL tol_missing: got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_edge_beats_timeout();
    rearm();
    gen(500, 500, 2, 1'b1);
    final_edge();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL edge_wins_missing: got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_timeout();
    int n;
    rearm();
    gen(2, 2, 3, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (ok_a !== 1'b1) begin errors++; $display("FAIL pre_timeout_freq_ok: got %b required 1", ok_a); end
    to_cyc.delete();
    allow_to = 1'b1;
    n = 0;
    while (to_cyc.size() < 3 && n < 3500) begin
      @(negedge clk);
      n++;
    end
    allow_to = 1'b0;
    checks++;
    if (to_cyc.size() < 3) begin
      errors++; $display("FAIL timeout_count: got %0d pulses required 3", to_cyc.size());
    end else begin
      checks++; if (to_cyc[1] - to_cyc[0] != 1000) begin errors++; $display("FAIL timeout_interval1: got %0d required 1000", to_cyc[1] - to_cyc[0]); end
      checks++; if (to_cyc[2] - to_cyc[1] != 1000) begin errors++; $display("FAIL timeout_interval2: got %0d required 1000", to_cyc[2] - to_cyc[1]); end
    end
    checks++; if (ok_a !== 1'b0) begin errors++; $display("FAIL timeout_freq_ok: got %b required 0", ok_a); end
    have_prev = 1'b0;
    gen(2, 2, 4, 1'b1);
    final_edge();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL resume_missing: got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_enable_and_reset();
    rearm();
    gen(2, 2, 3, 1'b1);
    repeat (6) @(negedge clk);
    enable = 1'b0;
    have_prev = 1'b0;
    gen(2, 2, 3, 1'b0);
    checks++; if (period_a !== W'(4)) begin errors++; $display("FAIL hold_period: got %0d required 4", period_a); end
    checks++; if (ok_a !== 1'b1) begin errors++; $display("FAIL hold_freq_ok: got %b required 1", ok_a); end
    enable = 1'b1;
    gen(2, 2, 1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({period_a, high_a, low_a} !== '0) begin errors++; $display("FAIL midreset_meas: got %0d/%0d/%0d required 0/0/0", period_a, high_a, low_a); end
    checks++; if ({mv_a, ok_a, to_a} !== 3'b000) begin errors++; $display("FAIL midreset_flags: got %b required 000", {mv_a, ok_a, to_a}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    have_prev = 1'b0;
    gen(2, 2, 4, 1'b1);
    final_edge();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL post_reset_missing: got %0d pending required 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_rate_change();
    test_tolerance();
    test_edge_beats_timeout();
    test_timeout();
    test_enable_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clk_freq_meter.md
CLK_FREQ_METER -- requirements
Module: clk_freq_meter

Interface
REQ-001 Parameter CNT_W, 16, width of all cycle counters and measurement outputs.
REQ-002 Parameter TIMEOUT, 1000, clk cycles without a sig_in rising edge before a timeout is declared (2 <= TIMEOUT <= 2^CNT_W-1).
REQ-003 Parameter EXP_PERIOD, 4, expected sig_in period in clk cycles.
REQ-004 Parameter TOL, 0, allowed absolute deviation from EXP_PERIOD in clk cycles.
REQ-005 clk  input  1  reference clock (100 MHz); all logic on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 enable  input  1  level; 1 = measure, 0 = idle.
REQ-008 sig_in  input  1  divided clock under test, asynchronous to clk.
REQ-009 period  output  CNT_W  clk cycles between two consecutive sig_in rising edges.
REQ-010 high_time  output  CNT_W  clk cycles sig_in was high within that period.
REQ-011 low_time  output  CNT_W  clk cycles sig_in was low within that period.
REQ-012 meas_valid  output  1  one-cycle pulse; period/high_time/low_time/freq_ok updated.
REQ-013 freq_ok  output  1  last period within EXP_PERIOD +/- TOL.
REQ-014 timeout  output  1  one-cycle pulse; no rising edge for TIMEOUT cycles.

Function
REQ-015 sig_in SHALL pass a 2-flop synchronizer followed by one delay flop; rising edge = sync=1 and delayed=0; edge seen 3 clk after sig_in rises (latency fixed).
REQ-016 FSM states SHALL be IDLE, ARM, MEASURE.
REQ-017 IDLE: counters cleared; enable=1 -> ARM next cycle.
REQ-018 ARM: wait for rising edge; on edge -> MEASURE with period counter=1 and high counter=1, low counter=0.
REQ-019 MEASURE: each cycle without edge, period counter +1 and high (sync=1) or low (sync=0) counter +1.
REQ-020 MEASURE on edge: period, high_time, low_time SHALL register counter values and meas_valid SHALL pulse next cycle; counters restart as in REQ-018 that same cycle (back-to-back, no edge lost).
REQ-021 freq_ok SHALL be registered with meas_valid: 1 iff |period - EXP_PERIOD| <= TOL, computed in CNT_W+1 bits, no wrap; holds until next meas_valid.
REQ-022 high_time + low_time SHALL equal period on every meas_valid.
REQ-023 Period counter reaching TIMEOUT without edge (ARM or MEASURE): timeout pulses one cycle, freq_ok cleared, FSM -> ARM, no meas_valid.
REQ-024 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-025 enable=0 in any state: -> IDLE next cycle, in-flight measurement discarded, no meas_valid/timeout; outputs period/high_time/low_time/freq_ok hold last values.
REQ-026 Edge and TIMEOUT in same cycle: edge wins (measurement reported, no timeout).
REQ-027 First edge after ARM SHALL NOT produce meas_valid.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: FSM IDLE, synchronizer/delay flops 0, all counters 0, period/high_time/low_time 0, meas_valid/freq_ok/timeout 0.
REQ-029 Reset release SHALL be synchronized (2-flop deassertion) inside the block; first enable-sampled state change no earlier than 2 clk after release.
REQ-030 Reset mid-MEASURE SHALL discard the measurement; no pulse on recovery until a full new period.

Structure
REQ-031 Shared package clk_meas_pkg SHALL hold the FSM state enum (IDLE, ARM, MEASURE) and default CNT_W.
REQ-032 Sub-module sync_edge_det SHALL contain the synchronizer, delay flop and rise output; all else in clk_freq_meter.

Verification
REQ-033 sig_in = 100MHz/4 (2 high, 2 low), EXP_PERIOD=4, TOL=0 -> every meas_valid after first: period=4, high_time=2, low_time=2, freq_ok=1.
REQ-034 sig_in period 160 (80/80), EXP_PERIOD=160, TOL=0 -> period=160, high_time=80, low_time=80, freq_ok=1; switch to 230 (115/115) -> period=230, freq_ok=0.
REQ-035 sig_in period 167 (84 high/83 low), EXP_PERIOD=168, TOL=1 -> period=167, high_time=84, low_time=83, freq_ok=1.
REQ-036 sig_in held 0, TIMEOUT=1000 -> timeout pulse every 1000 clk, meas_valid never asserts; restart toggling -> valid resumes after 2nd edge.
REQ-037 enable dropped mid-period, then rst_n pulsed mid-MEASURE -> no meas_valid/timeout; all outputs 0 after reset; first valid only after 2 edges.
